// File: rtl/lpm_arb_pkg.sv
// Shared types for the dual-port RAM arbiter: requester index, response
// pipeline stage and the default read latency of the registered RAM path.
package lpm_arb_pkg;

  typedef logic req_idx_t;

  localparam int RD_LATENCY_DEFAULT = 2;

  typedef struct packed {
    logic     valid;
    req_idx_t tag;
  } resp_stage_t;

endpackage

// File: rtl/lpm_rr_arb2.sv
// Two-way round-robin arbiter. With both requesting, the pointed-to requester
// wins and the pointer moves to the loser; the pointer moves only when advance=1.
module lpm_rr_arb2
  import lpm_arb_pkg::*;
(
  input  logic       clock,
  input  logic       aclr_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  req_idx_t ptr;

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | (ptr == 1'b0));
    gnt[1] = req[1] & (~req[0] | (ptr == 1'b1));
  end

  // After any accepted grant, priority passes to the other requester.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      ptr <= 1'b0;
    end else if (advance && (|gnt)) begin
      ptr <= req_idx_t'(gnt[0]);
    end
  end

endmodule

// File: rtl/lpm_ram_dp_arb.sv
// Shares one registered dual-port RAM between two writers and two readers,
// blocks same-address read-after-write in one cycle and tags read returns.
module lpm_ram_dp_arb
  import lpm_arb_pkg::*;
#(
  parameter int lpm_width   = 8,
  parameter int lpm_widthad = 4,
  parameter int rd_latency  = RD_LATENCY_DEFAULT
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   wr0_req,
  input  logic                   wr1_req,
  input  logic [lpm_widthad-1:0] wr0_addr,
  input  logic [lpm_widthad-1:0] wr1_addr,
  input  logic [lpm_width-1:0]   wr0_data,
  input  logic [lpm_width-1:0]   wr1_data,
  output logic                   wr0_gnt,
  output logic                   wr1_gnt,
  input  logic                   rd0_req,
  input  logic                   rd1_req,
  input  logic [lpm_widthad-1:0] rd0_addr,
  input  logic [lpm_widthad-1:0] rd1_addr,
  output logic                   rd0_gnt,
  output logic                   rd1_gnt,
  output logic                   rd0_valid,
  output logic                   rd1_valid,
  output logic [lpm_width-1:0]   rd_q,
  output logic [lpm_width-1:0]   ram_data,
  output logic [lpm_widthad-1:0] ram_wraddress,
  output logic                   ram_wren,
  output logic [lpm_widthad-1:0] ram_rdaddress,
  output logic                   ram_rden,
  input  logic [lpm_width-1:0]   ram_q
);

  // Handshake: a requester holds req (and its address/data) until it sees gnt;
  // the transfer happens in the cycle where req and gnt are both high.

  logic [1:0]                 wr_req;
  logic [1:0]                 wr_gnt;
  logic [1:0]                 rd_req;
  logic [1:0]                 rd_arb_gnt;
  logic                       rd_hazard;
  req_idx_t                   rd_win;
  logic [lpm_widthad-1:0]     rd_win_addr;
  resp_stage_t                resp_in;
  resp_stage_t                resp_out;
  resp_stage_t [rd_latency-1:0] resp_pipe;

  assign wr_req = {wr1_req, wr0_req} & {2{aclr_n}};
  assign rd_req = {rd1_req, rd0_req} & {2{aclr_n}};

  lpm_rr_arb2 u_wr_arb (
    .clock   (clock),
    .aclr_n  (aclr_n),
    .req     (wr_req),
    .advance (1'b1),
    .gnt     (wr_gnt)
  );

  // A suppressed read must not consume its turn, so advance is gated.
  lpm_rr_arb2 u_rd_arb (
    .clock   (clock),
    .aclr_n  (aclr_n),
    .req     (rd_req),
    .advance (~rd_hazard),
    .gnt     (rd_arb_gnt)
  );

  always_comb begin
    wr0_gnt       = wr_gnt[0];
    wr1_gnt       = wr_gnt[1];
    ram_wren      = |wr_gnt;
    ram_wraddress = wr_gnt[1] ? wr1_addr : wr0_addr;
    ram_data      = wr_gnt[1] ? wr1_data : wr0_data;

    rd_win        = req_idx_t'(rd_arb_gnt[1]);
    rd_win_addr   = rd_win ? rd1_addr : rd0_addr;
    rd_hazard     = ram_wren & (|rd_arb_gnt) & (rd_win_addr == ram_wraddress);
    rd0_gnt       = rd_arb_gnt[0] & ~rd_hazard;
    rd1_gnt       = rd_arb_gnt[1] & ~rd_hazard;
    ram_rden      = rd0_gnt | rd1_gnt;
    ram_rdaddress = rd_win_addr;

    resp_in.valid = ram_rden;
    resp_in.tag   = rd_win;
  end

  generate
    if (rd_latency > 1) begin : g_pipe_multi
      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          resp_pipe <= '0;
        end else begin
          resp_pipe <= {resp_pipe[rd_latency-2:0], resp_in};
        end
      end
    end else begin : g_pipe_single
      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          resp_pipe <= '0;
        end else begin
          resp_pipe <= resp_in;
        end
      end
    end
  endgenerate

  always_comb begin
    resp_out  = resp_pipe[rd_latency-1];
    rd0_valid = resp_out.valid & (resp_out.tag == 1'b0);
    rd1_valid = resp_out.valid & (resp_out.tag == 1'b1);
    rd_q      = ram_q;
  end

endmodule

// File: tb/tb_lpm_ram_dp_arb.sv
// Bench for lpm_ram_dp_arb: directed scenarios plus random traffic, with a
// registered RAM model attached and a cycle-level reference of the arbiter.
module tb_lpm_ram_dp_arb;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          aclr_n = 1'b0;
  logic          wr0_req = 1'b0, wr1_req = 1'b0;
  logic [AW-1:0] wr0_addr = '0, wr1_addr = '0;
  logic [W-1:0]  wr0_data = '0, wr1_data = '0;
  logic          wr0_gnt, wr1_gnt;
  logic          rd0_req = 1'b0, rd1_req = 1'b0;
  logic [AW-1:0] rd0_addr = '0, rd1_addr = '0;
  logic          rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
  logic [W-1:0]  rd_q, ram_data, ram_q;
  logic [AW-1:0] ram_wraddress, ram_rdaddress;
  logic          ram_wren, ram_rden;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  lpm_ram_dp_arb #(.lpm_width(W), .lpm_widthad(AW), .rd_latency(2)) dut (
    .clock(clock), .aclr_n(aclr_n),
    .wr0_req(wr0_req), .wr1_req(wr1_req),
    .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .wr0_gnt(wr0_gnt), .wr1_gnt(wr1_gnt),
    .rd0_req(rd0_req), .rd1_req(rd1_req),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_gnt(rd0_gnt), .rd1_gnt(rd1_gnt),
    .rd0_valid(rd0_valid), .rd1_valid(rd1_valid),
    .rd_q(rd_q), .ram_data(ram_data), .ram_wraddress(ram_wraddress),
    .ram_wren(ram_wren), .ram_rdaddress(ram_rdaddress), .ram_rden(ram_rden),
    .ram_q(ram_q)
  );

  // ---------------- RAM model: registered rdaddress and registered q ----------------
  logic [W-1:0]  ram_mem [2**AW];
  logic [AW-1:0] ram_rdaddr_r;
  logic [W-1:0]  ram_q_r;
  initial begin
    for (int i = 0; i < 2**AW; i++) ram_mem[i] = '0;
    ram_rdaddr_r = '0;
    ram_q_r = '0;
  end
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_wraddress] <= ram_data;
    ram_rdaddr_r <= ram_rdaddress;
    ram_q_r      <= ram_mem[ram_rdaddr_r];
  end
  assign ram_q = ram_q_r;

  // ---------------- reference model and scoreboard ----------------
  logic [W-1:0] mem_m [2**AW];
  int           wpri, rpri, cyc;
  int           due_q[$];
  int           tag_q[$];
  logic [W-1:0] exp_q[$];
  int           g_w, g_r;
  int           n_chk, n_pass;
  logic         s_wr0_gnt, s_wr1_gnt, s_rd0_gnt, s_rd1_gnt, s_rd0_valid, s_rd1_valid;
  logic [W-1:0] s_rd_q;
  logic [AW-1:0] s_wraddr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // One clock cycle: predict from the rules, compare at the negedge, advance the model.
  task automatic step();
    logic [AW-1:0] w_addr, r_addr;
    logic [W-1:0]  w_data;
    logic          e_v0, e_v1;
    @(negedge clock);
    s_wr0_gnt = wr0_gnt; s_wr1_gnt = wr1_gnt;
    s_rd0_gnt = rd0_gnt; s_rd1_gnt = rd1_gnt;
    s_rd0_valid = rd0_valid; s_rd1_valid = rd1_valid;
    s_rd_q = rd_q; s_wraddr = ram_wraddress;
    g_w = -1;
    g_r = -1;
    if (!aclr_n) begin
      wpri = 0;
      rpri = 0;
      due_q.delete();
      tag_q.delete();
      exp_q.delete();
    end else begin
      if (wr0_req && wr1_req) g_w = wpri;
      else if (wr0_req)       g_w = 0;
      else if (wr1_req)       g_w = 1;
      if (rd0_req && rd1_req) g_r = rpri;
      else if (rd0_req)       g_r = 0;
      else if (rd1_req)       g_r = 1;
    end
    w_addr = (g_w == 1) ? wr1_addr : wr0_addr;
    w_data = (g_w == 1) ? wr1_data : wr0_data;
    r_addr = (g_r == 1) ? rd1_addr : rd0_addr;
    if (g_w >= 0 && g_r >= 0 && w_addr == r_addr) g_r = -1;

    chk("wr0_gnt", 32'(wr0_gnt), 32'(g_w == 0));
    chk("wr1_gnt", 32'(wr1_gnt), 32'(g_w == 1));
    chk("rd0_gnt", 32'(rd0_gnt), 32'(g_r == 0));
    chk("rd1_gnt", 32'(rd1_gnt), 32'(g_r == 1));
    chk("ram_wren", 32'(ram_wren), 32'(g_w >= 0));
    chk("ram_rden", 32'(ram_rden), 32'(g_r >= 0));
    if (g_w >= 0) begin
      chk("ram_wraddress", 32'(ram_wraddress), 32'(w_addr));
      chk("ram_data", 32'(ram_data), 32'(w_data));
    end
    if (g_r >= 0) chk("ram_rdaddress", 32'(ram_rdaddress), 32'(r_addr));

    e_v0 = (due_q.size() > 0) && (due_q[0] == cyc) && (tag_q[0] == 0);
    e_v1 = (due_q.size() > 0) && (due_q[0] == cyc) && (tag_q[0] == 1);
    chk("rd0_valid", 32'(rd0_valid), 32'(e_v0));
    chk("rd1_valid", 32'(rd1_valid), 32'(e_v1));
    if (e_v0 || e_v1) begin
      chk("rd_q", 32'(rd_q), 32'(exp_q[0]));
      void'(due_q.pop_front());
      void'(tag_q.pop_front());
      void'(exp_q.pop_front());
    end

    if (g_r >= 0) begin
      due_q.push_back(cyc + 2);
      tag_q.push_back(g_r);
      exp_q.push_back(mem_m[r_addr]);
      rpri = 1 - g_r;
    end
    if (g_w >= 0) begin
      mem_m[w_addr] = w_data;
      wpri = 1 - g_w;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  int cnt_v0, cnt_v1, cnt_both;

  initial begin
    for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
    n_chk = 0; n_pass = 0; cyc = 0; wpri = 0; rpri = 0;

    // Reset with every requester asserted
    aclr_n = 1'b0;
    wr0_req = 1; wr1_req = 1; rd0_req = 1; rd1_req = 1;
    wr0_addr = 4'd1; wr1_addr = 4'd2; rd0_addr = 4'd1; rd1_addr = 4'd9;
    step();
    step();
    chk("rst_valids", 32'({s_rd0_valid, s_rd1_valid}), 32'd0);
    wr0_req = 0; wr1_req = 0; rd0_req = 0; rd1_req = 0;
    aclr_n = 1'b1;
    step();

    // Both writers held: alternate starting with wr0
    wr0_req = 1; wr0_addr = 4'd3; wr0_data = 8'h11;
    wr1_req = 1; wr1_addr = 4'd5; wr1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_wraddr", 32'(s_wraddr), (i % 2 == 1) ? 32'd5 : 32'd3);
      chk("t2_wr0_gnt", 32'(s_wr0_gnt), 32'(i % 2 == 0));
    end
    wr0_req = 0; wr1_req = 0;

    // Write then read the same address
    wr1_req = 1; wr1_addr = 4'd7; wr1_data = 8'hA5;
    step();
    chk("t3_wr1_gnt", 32'(s_wr1_gnt), 32'd1);
    wr1_req = 0;
    rd0_req = 1; rd0_addr = 4'd7;
    step();
    chk("t3_rd0_gnt", 32'(s_rd0_gnt), 32'd1);
    rd0_req = 0;
    step();
    chk("t3_rd0_valid_early", 32'(s_rd0_valid), 32'd0);
    step();
    chk("t3_rd0_valid", 32'(s_rd0_valid), 32'd1);
    chk("t3_rd1_valid", 32'(s_rd1_valid), 32'd0);
    chk("t3_rd_q", 32'(s_rd_q), 32'hA5);

    // Same-cycle write and read of one address: read deferred one cycle
    wr0_req = 1; wr0_addr = 4'd4; wr0_data = 8'h3C;
    rd1_req = 1; rd1_addr = 4'd4;
    step();
    chk("t4_wr0_gnt", 32'(s_wr0_gnt), 32'd1);
    chk("t4_rd1_gnt_blocked", 32'(s_rd1_gnt), 32'd0);
    wr0_req = 0;
    step();
    chk("t4_rd1_gnt", 32'(s_rd1_gnt), 32'd1);
    rd1_req = 0;
    step();
    step();
    chk("t4_rd1_valid", 32'(s_rd1_valid), 32'd1);
    chk("t4_rd_q", 32'(s_rd_q), 32'h3C);

    // Both readers streaming for 6 cycles
    cnt_v0 = 0; cnt_v1 = 0; cnt_both = 0;
    rd0_req = 1; rd0_addr = 4'd3;
    rd1_req = 1; rd1_addr = 4'd5;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) begin rd0_req = 0; rd1_req = 0; end
      step();
      cnt_v0 += int'(s_rd0_valid);
      cnt_v1 += int'(s_rd1_valid);
      cnt_both += int'(s_rd0_valid & s_rd1_valid);
    end
    chk("t5_rd0_count", 32'(cnt_v0), 32'd3);
    chk("t5_rd1_count", 32'(cnt_v1), 32'd3);
    chk("t5_overlap", 32'(cnt_both), 32'd0);

    // Reset right after a read grant discards the return
    rd0_req = 1; rd0_addr = 4'd7;
    step();
    chk("t6_rd0_gnt", 32'(s_rd0_gnt), 32'd1);
    rd0_req = 0;
    aclr_n = 1'b0;
    cnt_v0 = 0;
    step();
    cnt_v0 += int'(s_rd0_valid | s_rd1_valid);
    aclr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cnt_v0 += int'(s_rd0_valid | s_rd1_valid);
    end
    chk("t6_no_valid", 32'(cnt_v0), 32'd0);
    rd0_req = 1; rd1_req = 1; rd1_addr = 4'd5;
    step();
    chk("t6_rd0_first", 32'(s_rd0_gnt), 32'd1);
    chk("t6_rd1_wait", 32'(s_rd1_gnt), 32'd0);
    rd0_req = 0;
    step();
    rd1_req = 0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic with narrow address range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      aclr_n = (i == 200) ? 1'b0 : 1'b1;
      if (!wr0_req && $urandom_range(0, 99) < 60) begin
        wr0_req = 1;
        wr0_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        wr0_data = 8'($urandom_range(0, 255));
      end
      if (!wr1_req && $urandom_range(0, 99) < 60) begin
        wr1_req = 1;
        wr1_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        wr1_data = 8'($urandom_range(0, 255));
      end
      if (!rd0_req && $urandom_range(0, 99) < 60) begin
        rd0_req = 1;
        rd0_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      if (!rd1_req && $urandom_range(0, 99) < 60) begin
        rd1_req = 1;
        rd1_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      step();
      if (g_w == 0) wr0_req = 0;
      if (g_w == 1) wr1_req = 0;
      if (g_r == 0) rd0_req = 0;
      if (g_r == 1) rd1_req = 0;
    end

    // Drain outstanding reads
    aclr_n = 1'b1;
    wr0_req = 0; wr1_req = 0; rd0_req = 0; rd1_req = 0;
    for (int i = 0; i < 4; i++) step();
    chk("drain_empty", 32'(due_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lpm_ram_dp_arb.md
# lpm_ram_dp_arb

Single-clock arbiter that shares one dual-port RAM instance (`lpm_ram_dp`, all controls REGISTERED, rdclock = wrclock = `clock`) between two write requesters and two read requesters. It selects one writer and one reader per cycle with independent round-robin arbiters and drives the RAM write and read ports. It also blocks read-after-write hazards on the same address and returns tagged read data after the fixed RAM latency. It sits between the client blocks and the RAM in any shared-buffer datapath.

## Interface
Parameters:
- `lpm_width`, 8: data width.
- `lpm_widthad`, 4: address width.
- `rd_latency`, 2: cycles from read grant to `rd_q` valid. Fixed to the RAM's registered-rdaddress plus registered-output path.

Ports:
- `clock`  in  1: single clock, also drives RAM rdclock/wrclock.
- `aclr_n`  in  1: reset, asynchronous, active-low.
- `wr0_req`, `wr1_req`  in  1: write request, held until granted.
- `wr0_addr`, `wr1_addr`  in  lpm_widthad: write address.
- `wr0_data`, `wr1_data`  in  lpm_width: write data.
- `wr0_gnt`, `wr1_gnt`  out  1: write accepted this cycle (combinational).
- `rd0_req`, `rd1_req`  in  1: read request, held until granted.
- `rd0_addr`, `rd1_addr`  in  lpm_widthad: read address.
- `rd0_gnt`, `rd1_gnt`  out  1: read accepted this cycle (combinational).
- `rd0_valid`, `rd1_valid`  out  1: `rd_q` belongs to this requester this cycle.
- `rd_q`  out  lpm_width: read data, passed through from `ram_q`.
- `ram_data`  out  lpm_width: RAM write data.
- `ram_wraddress`  out  lpm_widthad: RAM write address.
- `ram_wren`  out  1: RAM write enable.
- `ram_rdaddress`  out  lpm_widthad: RAM read address.
- `ram_rden`  out  1: RAM read enable.
- `ram_q`  in  lpm_width: RAM output.

## Operation
Write arbitration:
- Each cycle, at most one write grant.
- Single requester: granted.
- Both requesting: the requester pointed to by `wptr` wins; `wptr` then moves to the loser.
- `wptr` changes only on a cycle with a grant.
- `ram_wren = wr0_gnt | wr1_gnt`. `ram_wraddress` and `ram_data` are muxed from the winner. With no grant they hold the wr0 values.

Read arbitration:
- Same scheme with `rptr`.
- `ram_rden = rd0_gnt | rd1_gnt`. `ram_rdaddress` is muxed from the winner.

Hazard rule:
- If the read winner's address equals the granted write address in the same cycle, the read grant is suppressed.
- In that case `ram_rden = 0` and `rptr` does not move.
- The requester stays pending and is granted next cycle if no new conflict exists. The read then returns the new data.

Response pipeline:
- Shift register of depth `rd_latency` carrying {valid, tag}.
- Stage 0 loads {`ram_rden`, winner index}.
- At the last stage, `rdN_valid` is asserted when valid=1 and tag=N.
- Read responses are never dropped or reordered; one response per cycle maximum.

Address range: every address `< 2**lpm_widthad` is legal. No bounds check.

## Timing
- Grant in cycle T → RAM registers the address at the end of T → `rdN_valid` and `rd_q` are valid in cycle T+`rd_latency` (T+2).
- A write granted in T is visible to a read granted in T+1 or later.
- Full throughput: one write and one read per cycle sustained.
- Reset (`aclr_n` = 0, asynchronous):
  - `wptr` = 0, `rptr` = 0 (requester 0 has priority first).
  - Response pipeline cleared.
  - All `rdN_valid` = 0.
  - Grant outputs follow the requests combinationally, but are forced to 0 while `aclr_n` = 0.
- Reset mid-operation: in-flight reads are discarded with no valid pulses. Requesters must re-issue them.
- After reset deassertion, the first grant is on the first rising edge with a request present.

## Structure
- Package `lpm_arb_pkg`: `req_idx_t` (1-bit requester index), `RD_LATENCY_DEFAULT` = 2, response stage struct {valid, tag}.
- Sub-module `lpm_rr_arb2` (2-way round-robin: req[1:0], advance, gnt[1:0], pointer flop).
  - Instantiated once for writes and once for reads.
  - The read instance's advance input is gated by the hazard check.
- The top level holds the muxes, the hazard comparator and the response shift register. It does not instantiate the RAM.

## Test plan
1. Reset: drive requests during `aclr_n` = 0 → all grants 0, `ram_wren` = 0, `ram_rden` = 0, `rd0_valid` = `rd1_valid` = 0.
2. `wr0_req` and `wr1_req` held for 4 cycles (addresses 3 and 5) → grants wr0, wr1, wr0, wr1; `ram_wraddress` = 3, 5, 3, 5.
3. wr1 writes 0xA5 to address 7, then rd0 reads address 7 → `rd0_valid` exactly 2 cycles after `rd0_gnt`, `rd_q` = 0xA5, `rd1_valid` stays 0.
4. Same cycle: wr0 writes 0x3C to address 4 and rd1 reads address 4 (old value 0x00) → `rd1_gnt` = 0 that cycle, 1 the next, then `rd_q` = 0x3C.
5. rd0 and rd1 request continuously for 6 cycles → one `rdN_valid` per cycle, alternating rd0/rd1, each with its correct addressed data.
6. `aclr_n` pulsed low 1 cycle after a read grant → no `rdN_valid` pulse follows; the next simultaneous read requests grant rd0 first.
